// File: rtl/timer_share_sequencer.sv
// Round-robin sharer of one Avalon-MM interval timer, used as one-shot timeouts.
// Optional TIMER_SEQ_SNAPSHOT_EN adds a counter snapshot on cancel (remaining/remaining_valid).
module timer_share_sequencer #(
  parameter int NUM_CLIENTS = 4,
  parameter int RR_INIT     = 0
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [NUM_CLIENTS-1:0]   req,
  input  logic [32*NUM_CLIENTS-1:0] req_period,
  input  logic [NUM_CLIENTS-1:0]   cancel,
  output logic [NUM_CLIENTS-1:0]   grant,
  output logic [NUM_CLIENTS-1:0]   done,
  output logic                     busy,
  output logic [2:0]               avm_address,
  output logic                     avm_chipselect,
  output logic                     avm_write_n,
  output logic [15:0]              avm_writedata,
  input  logic [15:0]              avm_readdata,
  input  logic                     timer_irq
`ifdef TIMER_SEQ_SNAPSHOT_EN
  ,
  output logic [31:0]              remaining,
  output logic                     remaining_valid
`endif
);

  localparam int IW = (NUM_CLIENTS > 1) ? $clog2(NUM_CLIENTS) : 1;

  localparam logic [2:0]  ADDR_STATUS  = 3'd0;
  localparam logic [2:0]  ADDR_CONTROL = 3'd1;
  localparam logic [2:0]  ADDR_PERL    = 3'd2;
  localparam logic [2:0]  ADDR_PERH    = 3'd3;
  localparam logic [15:0] CTRL_START   = 16'h0005;
  localparam logic [15:0] CTRL_STOP    = 16'h0008;

  typedef enum logic [3:0] {
    IDLE, GNT, PRE_CLR, PL, PH, CTRL, WAIT, CANCEL, CLR
`ifdef TIMER_SEQ_SNAPSHOT_EN
    , SNAP, RDL, RDH, RDW
`endif
  } state_t;

  state_t        state;
  logic [IW-1:0] rr_ptr;
  logic [IW-1:0] owner;
  logic [31:0]   period;
  logic [IW-1:0] pick;
  logic          pick_found;
  logic [IW-1:0] next_ptr;

`ifdef TIMER_SEQ_SNAPSHOT_EN
  localparam logic [2:0] ADDR_SNAPL = 3'd4;
  localparam logic [2:0] ADDR_SNAPH = 3'd5;
  logic [15:0] snap_lo;
  logic [15:0] snap_hi;
`else
  logic unused_readdata;
  assign unused_readdata = ^avm_readdata;
`endif

  // First asserted request scanning upward from rr_ptr, wrapping modulo NUM_CLIENTS.
  always_comb begin
    pick       = '0;
    pick_found = 1'b0;
    for (int unsigned k = 0; k < NUM_CLIENTS; k++) begin
      if (!pick_found && req[(32'(rr_ptr) + k) % NUM_CLIENTS]) begin
        pick_found = 1'b1;
        pick       = IW'((32'(rr_ptr) + k) % NUM_CLIENTS);
      end
    end
    next_ptr = (pick == IW'(NUM_CLIENTS - 1)) ? '0 : pick + 1'b1;
  end

  // Bus outputs are registered and loaded on entry to the state that owns the cycle,
  // so the state register and the visible bus transaction always line up.
  always_ff @(posedge clk) begin
    if (reset) begin
      state          <= IDLE;
      rr_ptr         <= IW'(RR_INIT);
      owner          <= '0;
      period         <= '0;
      grant          <= '0;
      done           <= '0;
      busy           <= 1'b0;
      avm_address    <= '0;
      avm_chipselect <= 1'b0;
      avm_write_n    <= 1'b1;
      avm_writedata  <= '0;
`ifdef TIMER_SEQ_SNAPSHOT_EN
      snap_lo         <= '0;
      snap_hi         <= '0;
      remaining       <= '0;
      remaining_valid <= 1'b0;
`endif
    end else begin
      avm_address    <= '0;
      avm_chipselect <= 1'b0;
      avm_write_n    <= 1'b1;
      avm_writedata  <= '0;
      done           <= '0;
`ifdef TIMER_SEQ_SNAPSHOT_EN
      remaining_valid <= 1'b0;
`endif
      case (state)
        IDLE: begin
          if (pick_found) begin
            owner  <= pick;
            period <= req_period[32*32'(pick) +: 32];
            grant  <= NUM_CLIENTS'(1) << pick;
            rr_ptr <= next_ptr;
            busy   <= 1'b1;
            state  <= GNT;
          end
        end
        GNT: begin
          avm_chipselect <= 1'b1;
          avm_write_n    <= 1'b0;
          avm_address    <= ADDR_STATUS;
          state          <= PRE_CLR;
        end
        PRE_CLR: begin
          avm_chipselect <= 1'b1;
          avm_write_n    <= 1'b0;
          avm_address    <= ADDR_PERL;
          avm_writedata  <= period[15:0];
          state          <= PL;
        end
        PL: begin
          avm_chipselect <= 1'b1;
          avm_write_n    <= 1'b0;
          avm_address    <= ADDR_PERH;
          avm_writedata  <= period[31:16];
          state          <= PH;
        end
        PH: begin
          avm_chipselect <= 1'b1;
          avm_write_n    <= 1'b0;
          avm_address    <= ADDR_CONTROL;
          avm_writedata  <= CTRL_START;
          state          <= CTRL;
        end
        CTRL: state <= WAIT;
        WAIT: begin
          // irq has priority over a simultaneous cancel so the timeout is still reported.
          if (timer_irq) begin
            avm_chipselect <= 1'b1;
            avm_write_n    <= 1'b0;
            avm_address    <= ADDR_STATUS;
            done[owner]    <= 1'b1;
            state          <= CLR;
          end else if (cancel[owner]) begin
            avm_chipselect <= 1'b1;
            avm_write_n    <= 1'b0;
`ifdef TIMER_SEQ_SNAPSHOT_EN
            avm_address    <= ADDR_SNAPL;
            state          <= SNAP;
`else
            avm_address    <= ADDR_CONTROL;
            avm_writedata  <= CTRL_STOP;
            state          <= CANCEL;
`endif
          end
        end
`ifdef TIMER_SEQ_SNAPSHOT_EN
        SNAP: begin
          avm_chipselect <= 1'b1;
          avm_address    <= ADDR_SNAPL;
          state          <= RDL;
        end
        RDL: begin
          avm_chipselect <= 1'b1;
          avm_address    <= ADDR_SNAPH;
          state          <= RDH;
        end
        RDH: begin
          snap_lo <= avm_readdata;
          state   <= RDW;
        end
        RDW: begin
          snap_hi        <= avm_readdata;
          avm_chipselect <= 1'b1;
          avm_write_n    <= 1'b0;
          avm_address    <= ADDR_CONTROL;
          avm_writedata  <= CTRL_STOP;
          state          <= CANCEL;
        end
`endif
        CANCEL: begin
          avm_chipselect <= 1'b1;
          avm_write_n    <= 1'b0;
          avm_address    <= ADDR_STATUS;
`ifdef TIMER_SEQ_SNAPSHOT_EN
          remaining       <= {snap_hi, snap_lo};
          remaining_valid <= 1'b1;
`endif
          state          <= CLR;
        end
        CLR: begin
          grant <= '0;
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_timer_share_sequencer.sv
// Directed self-checking bench for timer_share_sequencer (NUM_CLIENTS=4, RR_INIT=0).
// Covers the TIMER_SEQ_SNAPSHOT_EN cancel path when that macro is defined.
module tb_timer_share_sequencer;
  localparam int N = 4;

  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic [N-1:0]      req = '0;
  logic [32*N-1:0]   req_period = '0;
  logic [N-1:0]      cancel = '0;
  logic [N-1:0]      grant;
  logic [N-1:0]      done;
  logic              busy;
  logic [2:0]        avm_address;
  logic              avm_chipselect;
  logic              avm_write_n;
  logic [15:0]       avm_writedata;
  logic [15:0]       avm_readdata = '0;
  logic              timer_irq = 1'b0;
`ifdef TIMER_SEQ_SNAPSHOT_EN
  logic [31:0]       remaining;
  logic              remaining_valid;
`endif

  int checks = 0;
  int errors = 0;

  timer_share_sequencer #(.NUM_CLIENTS(N), .RR_INIT(0)) dut (
    .clk(clk), .reset(reset), .req(req), .req_period(req_period), .cancel(cancel),
    .grant(grant), .done(done), .busy(busy),
    .avm_address(avm_address), .avm_chipselect(avm_chipselect), .avm_write_n(avm_write_n),
    .avm_writedata(avm_writedata), .avm_readdata(avm_readdata), .timer_irq(timer_irq)
`ifdef TIMER_SEQ_SNAPSHOT_EN
    , .remaining(remaining), .remaining_valid(remaining_valid)
`endif
  );

  always #5 clk = ~clk;

  // Timer read port: snapshot counter is 0x0000_1234, readdata registered one cycle.
  always @(posedge clk) begin
    if (avm_chipselect && avm_write_n && avm_address == 3'd4)      avm_readdata <= 16'h1234;
    else if (avm_chipselect && avm_write_n && avm_address == 3'd5) avm_readdata <= 16'h0000;
    else                                                            avm_readdata <= 16'hdead;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_write(input string tag, input logic [2:0] a, input logic [15:0] d);
    logic [20:0] e;
    e = {1'b1, 1'b0, a, d};
    check(tag, {avm_chipselect, avm_write_n, avm_address, avm_writedata}, e);
  endtask

  task automatic expect_read(input string tag, input logic [2:0] a);
    logic [20:0] e;
    e = {1'b1, 1'b1, a, 16'h0000};
    check(tag, {avm_chipselect, avm_write_n, avm_address, avm_writedata}, e);
  endtask

  task automatic expect_idle(input string tag);
    logic [20:0] e;
    e = {1'b0, 1'b1, 3'd0, 16'h0000};
    check(tag, {avm_chipselect, avm_write_n, avm_address, avm_writedata}, e);
  endtask

  task automatic wait_grant(input string tag, input logic [N-1:0] exp);
    for (int i = 0; i < 20; i++) begin
      tick();
      if (grant != '0) break;
    end
    check(tag, grant, exp);
  endtask

  task automatic wait_ctrl(input string tag);
    logic found;
    found = 1'b0;
    for (int i = 0; i < 12; i++) begin
      tick();
      if (avm_chipselect && !avm_write_n && avm_address == 3'd1 && avm_writedata == 16'h0005) begin
        found = 1'b1;
        break;
      end
    end
    check(tag, found, 1'b1);
  endtask

  initial begin
    logic [N-1:0] rr_exp [4];
    rr_exp[0] = 4'b0001; rr_exp[1] = 4'b0010; rr_exp[2] = 4'b1000; rr_exp[3] = 4'b0001;

    // Reset state
    repeat (2) tick();
    check("rst_grant", grant, 0);
    check("rst_done", done, 0);
    check("rst_busy", busy, 0);
    expect_idle("rst_bus");
    reset = 1'b0;
    tick();

    // Single grant, client 2, period 0x0001_0005
    req_period[64 +: 32] = 32'h0001_0005;
    req = 4'b0100;
    tick();
    check("sg_grant_lat", grant, 4'b0100);
    check("sg_busy", busy, 1);
    expect_idle("sg_bus_quiet");
    tick(); expect_write("sg_preclr", 3'd0, 16'h0000);
    tick(); expect_write("sg_pl", 3'd2, 16'h0005);
    tick(); expect_write("sg_ph", 3'd3, 16'h0001);
    tick(); expect_write("sg_ctrl", 3'd1, 16'h0005);
    tick(); expect_idle("sg_wait_bus");
    check("sg_wait_done", done, 0);
    timer_irq = 1'b1;
    tick();
    expect_write("sg_clr", 3'd0, 16'h0000);
    check("sg_done", done, 4'b0100);
    check("sg_grant_hold", grant, 4'b0100);
    timer_irq = 1'b0;
    req = '0;
    tick();
    check("sg_grant_off", grant, 0);
    check("sg_done_pulse", done, 0);
    check("sg_idle_busy", busy, 0);

    // Cancel by owner 1; a non-owner cancel in WAIT is ignored first
    req_period[32 +: 32] = 32'd100;
    req = 4'b0010;
    wait_grant("cx_grant", 4'b0010);
    wait_ctrl("cx_ctrl");
    tick();
    cancel = 4'b0001;
    tick();
    expect_idle("cx_nonowner");
    check("cx_nonowner_grant", grant, 4'b0010);
    cancel = 4'b0010;
    req = '0;
    tick();
    cancel = '0;
`ifdef TIMER_SEQ_SNAPSHOT_EN
    expect_write("cx_snap", 3'd4, 16'h0000);
    tick(); expect_read("cx_rdl", 3'd4);
    tick(); expect_read("cx_rdh", 3'd5);
    tick(); expect_idle("cx_rdw");
    tick();
`endif
    expect_write("cx_stop", 3'd1, 16'h0008);
    check("cx_stop_done", done, 0);
    tick();
    expect_write("cx_clr", 3'd0, 16'h0000);
    check("cx_clr_done", done, 0);
`ifdef TIMER_SEQ_SNAPSHOT_EN
    check("cx_remaining", remaining, 32'h0000_1234);
    check("cx_rem_valid", remaining_valid, 1);
`endif
    tick();
    check("cx_grant_off", grant, 0);

    // Simultaneous irq and cancel, client 3 with period 0
    req_period[96 +: 32] = 32'd0;
    req = 4'b1000;
    wait_grant("sim_grant", 4'b1000);
    tick(); expect_write("sim_preclr", 3'd0, 16'h0000);
    tick(); expect_write("sim_pl0", 3'd2, 16'h0000);
    tick(); expect_write("sim_ph0", 3'd3, 16'h0000);
    tick(); expect_write("sim_ctrl", 3'd1, 16'h0005);
    tick();
    timer_irq = 1'b1;
    cancel = 4'b1000;
    tick();
    expect_write("sim_clr", 3'd0, 16'h0000);
    check("sim_done", done, 4'b1000);
    timer_irq = 1'b0;
    cancel = '0;
    req = '0;
    tick();
    expect_idle("sim_no_stop");
    check("sim_grant_off", grant, 0);

    // Round-robin with req = 1011 held
    for (int k = 0; k < 4; k++) req_period[32*k +: 32] = 32'd10;
    req = 4'b1011;
    for (int k = 0; k < 4; k++) begin
      wait_grant($sformatf("rr_grant%0d", k), rr_exp[k]);
      check($sformatf("rr_onehot%0d", k), $countones(grant), 1);
      wait_ctrl($sformatf("rr_ctrl%0d", k));
      tick();
      timer_irq = 1'b1;
      tick();
      check($sformatf("rr_done%0d", k), done, rr_exp[k]);
      timer_irq = 1'b0;
      if (k == 3) req = '0;
      tick();
      check($sformatf("rr_gap%0d", k), grant, 0);
    end

    // Reset in PH, then restart from PRE_CLR
    req = 4'b0001;
    wait_grant("rph_grant", 4'b0001);
    tick(); expect_write("rph_preclr", 3'd0, 16'h0000);
    tick(); expect_write("rph_pl", 3'd2, 16'h000a);
    tick(); expect_write("rph_ph", 3'd3, 16'h0000);
    reset = 1'b1;
    tick();
    expect_idle("rph_bus");
    check("rph_grant_off", grant, 0);
    check("rph_busy", busy, 0);
    reset = 1'b0;
    wait_grant("rph_regrant", 4'b0001);
    tick(); expect_write("rph_restart", 3'd0, 16'h0000);
    wait_ctrl("rph_ctrl");
    tick();
    timer_irq = 1'b1;
    tick();
    check("rph_done", done, 4'b0001);
    timer_irq = 1'b0;
    req = '0;
    tick();
    check("rph_end", grant, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
